term_quantizer_grp: RTL and testbench

//  Group term quantizer. CH channels enter bit-plane-serial, MSB plane first, one plane per accepted beat.

---
 rtl/term_quantizer_grp_pkg.sv | 25 ++
 rtl/term_quantizer_grp_keep_first_n.sv | 25 ++
 rtl/term_quantizer_grp.sv | 161 ++++++++++++++++
 tb/tb_term_quantizer_grp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/term_quantizer_grp_pkg.sv
// Shared widths and helpers for the group term quantizer.
// Derived widths, a generic popcount, and the budget value that disables limiting.
package term_quant_pkg;

  localparam logic [31:0] BYPASS_BUDGET = '0;

  function automatic int calc_exp_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  function automatic int calc_bud_w(input int ch, input int data_w);
    return $clog2(ch * data_w + 1);
  endfunction

  // Supports planes up to 32 channels wide; callers zero-extend.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/term_quantizer_grp_keep_first_n.sv
// Combinational prefix-count mask: keeps the n lowest-index set bits of bits.
// NW must be wide enough to hold N.
module keep_first_n #(
  parameter int N  = 4,
  parameter int NW = 3
) (
  input  logic [N-1:0]  bits,
  input  logic [NW-1:0] n,
  output logic [N-1:0]  mask
);

  logic [NW-1:0] seen;

  always_comb begin
    mask = '0;
    seen = '0;
    for (int i = 0; i < N; i++) begin
      if (bits[i] && (seen < n)) begin
        mask[i] = 1'b1;
      end
      seen = seen + {{(NW-1){1'b0}}, bits[i]};
    end
  end

endmodule

// File: rtl/term_quantizer_grp.sv
// Group term quantizer: bit-plane-serial input, keeps the largest power-of-two terms
// of a channel group under a shared per-frame budget, two-stage valid/ready pipeline.
module term_quantizer_grp
  import term_quant_pkg::*;
#(
  parameter int   CH     = 4,
  parameter int   DATA_W = 8,
  localparam int  EXP_W  = calc_exp_w(DATA_W),
  localparam int  BUD_W  = calc_bud_w(CH, DATA_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH-1:0]    in_bits,
  input  logic [CH-1:0]    in_sign,
  input  logic [BUD_W-1:0] cfg_budget,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH-1:0]    out_mask,
  output logic [EXP_W-1:0] out_exp,
  output logic [CH-1:0]    out_sign,
  output logic             out_first,
  output logic             out_last,
  output logic             out_trunc
);

  localparam logic [EXP_W-1:0] TOP_PLANE = EXP_W'(DATA_W - 1);

  logic             en;
  logic             accept;
  logic             first_plane;
  logic [EXP_W-1:0] plane_cnt;

  logic             vld_p1;
  logic [CH-1:0]    bits_p1;
  logic [EXP_W-1:0] exp_p1;
  logic             first_p1;
  logic             last_p1;
  logic [CH-1:0]    sign_p1;
  logic [BUD_W-1:0] bud_p1;

  logic             vld_p2;
  logic [CH-1:0]    mask_p2;
  logic [EXP_W-1:0] exp_p2;
  logic [CH-1:0]    sign_p2;
  logic             first_p2;
  logic             last_p2;
  logic             trunc_p2;

  logic [BUD_W-1:0] rem_q;
  logic             trunc_q;

  logic             bypass;
  logic [BUD_W-1:0] rem_eff;
  logic             sticky_eff;
  logic [BUD_W-1:0] pop;
  logic [CH-1:0]    kept;
  logic [CH-1:0]    mask_nxt;
  logic [BUD_W-1:0] rem_nxt;
  logic             sticky_nxt;

  // Whole pipeline advances together; a full output stage blocks everything upstream.
  assign en          = ~vld_p2 | out_ready;
  assign in_ready    = en;
  assign accept      = in_valid & en;
  assign first_plane = (plane_cnt == TOP_PLANE);

  // ---- Stage 1: plane register, exponent tagging, frame capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      plane_cnt <= TOP_PLANE;
    end else if (en) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        first_p1  <= first_plane;
        last_p1   <= (plane_cnt == '0);
        plane_cnt <= (plane_cnt == '0) ? TOP_PLANE : plane_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      bits_p1 <= in_bits;
      exp_p1  <= plane_cnt;
      if (first_plane) begin
        sign_p1 <= in_sign;
        bud_p1  <= cfg_budget;
      end
    end
  end

  // ---- Stage 2: budgeted term selection ----
  assign bypass     = (bud_p1 == BUD_W'(BYPASS_BUDGET));
  assign rem_eff    = first_p1 ? bud_p1 : rem_q;
  assign sticky_eff = first_p1 ? 1'b0 : trunc_q;
  assign pop        = BUD_W'(popcount(32'(bits_p1)));

  keep_first_n #(
    .N  (CH),
    .NW (BUD_W)
  ) u_keep (
    .bits (bits_p1),
    .n    (rem_eff),
    .mask (kept)
  );

  always_comb begin
    mask_nxt   = bits_p1;
    rem_nxt    = rem_eff;
    sticky_nxt = sticky_eff;
    if (!bypass) begin
      if (pop <= rem_eff) begin
        rem_nxt = rem_eff - pop;
      end else begin
        mask_nxt   = kept;
        rem_nxt    = '0;
        sticky_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2   <= 1'b0;
      rem_q    <= '0;
      trunc_q  <= 1'b0;
      mask_p2  <= '0;
      exp_p2   <= '0;
      sign_p2  <= '0;
      first_p2 <= 1'b0;
      last_p2  <= 1'b0;
      trunc_p2 <= 1'b0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        rem_q    <= rem_nxt;
        trunc_q  <= sticky_nxt;
        mask_p2  <= mask_nxt;
        exp_p2   <= exp_p1;
        sign_p2  <= sign_p1;
        first_p2 <= first_p1;
        last_p2  <= last_p1;
        trunc_p2 <= last_p1 & sticky_nxt;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_mask  = mask_p2;
  assign out_exp   = exp_p2;
  assign out_sign  = sign_p2;
  assign out_first = first_p2;
  assign out_last  = last_p2;
  assign out_trunc = trunc_p2;

endmodule

// File: tb/tb_term_quantizer_grp.sv
// Randomized bench for term_quantizer_grp: a greedy term-by-term frame model feeds
// an expected-beat queue that is compared against every output beat, stalled or not.
module tb_term_quantizer_grp;

  localparam int CH     = 4;
  localparam int DATA_W = 8;
  localparam int EXP_W  = 3;
  localparam int BUD_W  = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [CH-1:0]    in_bits;
  logic [CH-1:0]    in_sign;
  logic [BUD_W-1:0] cfg_budget;
  logic             out_valid;
  logic             out_ready;
  logic [CH-1:0]    out_mask;
  logic [EXP_W-1:0] out_exp;
  logic [CH-1:0]    out_sign;
  logic             out_first;
  logic             out_last;
  logic             out_trunc;

  typedef struct packed {
    logic [CH-1:0]    mask;
    logic [EXP_W-1:0] exp;
    logic [CH-1:0]    sign;
    logic             first;
    logic             last;
    logic             trunc;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    sb_on  = 1'b0;
  bit    rnd_ready = 1'b0;

  term_quantizer_grp #(.CH(CH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .in_sign    (in_sign),
    .cfg_budget (cfg_budget),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mask   (out_mask),
    .out_exp    (out_exp),
    .out_sign   (out_sign),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_trunc  (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
  endtask

  // Greedy reference: walk terms from largest exponent down, channel 0 first,
  // keeping each while budget remains; budget 0 means unlimited.
  task automatic model_frame(input logic [DATA_W-1:0][CH-1:0] pl,
                             input logic [CH-1:0] sgn, input int bud);
    int    left;
    bit    dropped;
    beat_t b;
    left    = bud;
    dropped = 1'b0;
    for (int e = DATA_W - 1; e >= 0; e--) begin
      b = '0;
      for (int c = 0; c < CH; c++) begin
        if (pl[e][c]) begin
          if (bud == 0 || left > 0) begin
            b.mask[c] = 1'b1;
            if (bud != 0) left--;
          end else begin
            dropped = 1'b1;
          end
        end
      end
      b.exp   = EXP_W'(e);
      b.sign  = sgn;
      b.first = (e == DATA_W - 1);
      b.last  = (e == 0);
      b.trunc = (e == 0) && dropped;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [CH-1:0] b, input logic [CH-1:0] s,
                           input logic [BUD_W-1:0] bud);
    bit acc;
    int t;
    t          = 0;
    in_valid   = 1'b1;
    in_bits    = b;
    in_sign    = s;
    cfg_budget = bud;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_bits  = CH'($urandom);
  endtask

  // Non-first beats carry junk sign/budget to show they are ignored.
  task automatic send_frame(input logic [DATA_W-1:0][CH-1:0] pl,
                            input logic [CH-1:0] sgn, input int bud);
    model_frame(pl, sgn, bud);
    for (int e = DATA_W - 1; e >= 0; e--) begin
      if (e == DATA_W - 1) send_beat(pl[e], sgn, BUD_W'(bud));
      else                 send_beat(pl[e], CH'($urandom), BUD_W'($urandom));
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (sb_on && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        chk("mask",  32'(out_mask),  32'(exp_q[0].mask));
        chk("exp",   32'(out_exp),   32'(exp_q[0].exp));
        chk("sign",  32'(out_sign),  32'(exp_q[0].sign));
        chk("first", 32'(out_first), 32'(exp_q[0].first));
        chk("last",  32'(out_last),  32'(exp_q[0].last));
        chk("trunc", 32'(out_trunc), 32'(exp_q[0].trunc));
        if (out_ready) void'(exp_q.pop_front());
        else chk("in_ready_stall", 32'(in_ready), 32'd0);
      end
    end
  end

  initial begin
    logic [DATA_W-1:0][CH-1:0] pl;
    int bud;
    int t;

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_bits    = '0;
    in_sign    = '0;
    cfg_budget = '0;
    out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_mask",  32'(out_mask),  32'd0);
    chk("rst_exp",   32'(out_exp),   32'd0);
    chk("rst_sign",  32'(out_sign),  32'd0);
    chk("rst_first", 32'(out_first), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_trunc", 32'(out_trunc), 32'd0);

    // Latency: one beat, output appears exactly two edges after acceptance.
    @(posedge clk);
    #1;
    reset      = 1'b0;
    in_valid   = 1'b1;
    in_bits    = 4'b1111;
    in_sign    = 4'b1010;
    cfg_budget = 6'd2;
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid_1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_2", 32'(out_valid), 32'd1);
    chk("lat_exp",     32'(out_exp),   32'd7);
    chk("lat_first",   32'(out_first), 32'd1);
    chk("lat_mask",    32'(out_mask),  32'h3);
    chk("lat_sign",    32'(out_sign),  32'ha);
    @(posedge clk);
    #1;
    send_beat(4'b1111, 4'b0000, 6'd9);
    send_beat(4'b0110, 4'b0000, 6'd9);

    // Reset mid-frame; the scoreboard then expects a fresh frame from plane 7.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    sb_on = 1'b1;

    send_frame({4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111}
               << (CH * (DATA_W - 1)), 4'b0101, 2);
    send_frame(32'h5000_0000, 4'b1100, 0);
    send_frame(32'hF010_0000, 4'b0011, 3);
    send_frame(32'h3F00_0000, 4'b1001, 5);
    send_frame(32'hFFFF_FFFF, 4'b1111, 63);
    send_frame(32'hFFFF_FFFF, 4'b0110, 32);
    send_frame(32'hFFFF_FFFF, 4'b0001, 31);

    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      pl = $urandom;
      if ($urandom_range(0, 1) == 1) pl = pl & $urandom;
      case ($urandom_range(0, 3))
        0:       bud = 0;
        1:       bud = $urandom_range(1, 8);
        2:       bud = $urandom_range(9, 32);
        default: bud = $urandom_range(33, 63);
      endcase
      send_frame(pl, CH'($urandom), bud);
    end

    rnd_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
